// File: rtl/fe_mul_arbiter.sv
// ---------------------------------------------------------------------------
// fe_mul_arbiter
//
// Lets N_CH curve-operation controllers share one field multiplier. Each
// channel can have one request outstanding. The arbiter latches that request,
// issues latched requests to the multiplier one at a time, and returns each
// result to the channel that owns it.
//
// Handshake semantics (client side and multiplier side):
//   * ch_valid[i] is a one-cycle request pulse. It is accepted on a rising
//     edge where ch_busy[i] is low. The operands on ch_op_a/ch_op_b slice i
//     are captured on that same edge. ch_busy[i] rises in the next cycle.
//     A pulse while ch_busy[i] is high is not accepted and sets err.
//   * ch_done[i] pulses for one cycle with the result on ch_res. ch_busy[i]
//     falls in that same cycle, so the channel may request again right away.
//   * mul_valid pulses for one cycle while mul_op_a/mul_op_b are stable.
//     The multiplier answers with a one-cycle mul_done pulse and mul_res.
//     A mul_done that arrives when no answer is awaited is ignored.
//
// Parameters:
//   N_CH      number of client channels (2..8)
//   FE_W      field-element width in bits
//   ARB_MODE  0 = round-robin, 1 = fixed priority (lowest index wins)
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   ch_op_a, ch_op_b    packed per-channel operands, channel i at [i*FE_W +: FE_W]
//   ch_valid            per-channel request pulses
//   ch_busy             per-channel "request accepted, not yet answered"
//   ch_done             per-channel completion pulses
//   ch_res              shared result bus, held until the next completion
//   err                 sticky protocol-violation flag
//   mul_op_a, mul_op_b  registered multiplier operands
//   mul_valid           multiplier start pulse
//   mul_res, mul_done   multiplier result and completion pulse
//
// The FSM state is held in the signal 'state' (S_IDLE/S_ISSUE/S_WAIT).
// ---------------------------------------------------------------------------
module fe_mul_arbiter #(
    parameter int N_CH     = 4,
    parameter int FE_W     = 320,
    parameter int ARB_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*FE_W-1:0]   ch_op_a,
    input  logic [N_CH*FE_W-1:0]   ch_op_b,
    input  logic [N_CH-1:0]        ch_valid,
    output logic [N_CH-1:0]        ch_busy,
    output logic [N_CH-1:0]        ch_done,
    output logic [FE_W-1:0]        ch_res,
    output logic                   err,
    output logic [FE_W-1:0]        mul_op_a,
    output logic [FE_W-1:0]        mul_op_b,
    output logic                   mul_valid,
    input  logic [FE_W-1:0]        mul_res,
    input  logic                   mul_done
);

    localparam int PW = $clog2(N_CH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [N_CH-1:0]   pend;
    logic [FE_W-1:0]   lat_a [N_CH];
    logic [FE_W-1:0]   lat_b [N_CH];
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     owner;

    // Winner selection
    logic [PW-1:0]     win;
    logic              found;
    logic [PW-1:0]     cand;
    logic [PW:0]       sum;

    // Scan N_CH candidates. In round-robin mode the scan starts at ptr and
    // wraps; the extra sum bit keeps ptr+off from overflowing before the wrap.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        sum   = '0;
        for (int off = 0; off < N_CH; off++) begin
            if (ARB_MODE == 1) begin
                cand = PW'(off);
            end else begin
                sum = {1'b0, ptr} + (PW+1)'(off);
                if (sum >= (PW+1)'(N_CH)) begin
                    sum = sum - (PW+1)'(N_CH);
                end
                cand = sum[PW-1:0];
            end
            if (!found && pend[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mul_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        mul_valid = (state == S_ISSUE);
        ch_busy   = pend;
    end

    // Request latches, grant bookkeeping and result return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            ptr      <= '0;
            owner    <= '0;
            mul_op_a <= '0;
            mul_op_b <= '0;
            ch_res   <= '0;
            ch_done  <= '0;
            err      <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                lat_a[i] <= '0;
                lat_b[i] <= '0;
            end
        end else begin
            ch_done <= '0;

            // A pulse on a busy channel keeps the original operands.
            for (int i = 0; i < N_CH; i++) begin
                if (ch_valid[i]) begin
                    if (pend[i]) begin
                        err <= 1'b1;
                    end else begin
                        lat_a[i] <= ch_op_a[i*FE_W +: FE_W];
                        lat_b[i] <= ch_op_b[i*FE_W +: FE_W];
                        pend[i]  <= 1'b1;
                    end
                end
            end

            if (state == S_IDLE && found) begin
                mul_op_a <= lat_a[win];
                mul_op_b <= lat_b[win];
                owner    <= win;
                if (ARB_MODE == 0) begin
                    ptr <= (win == PW'(N_CH - 1)) ? '0 : win + 1'b1;
                end
            end

            // pend[owner] is still set here, so the capture loop above cannot
            // have touched it; clearing it cannot race a new request.
            if (state == S_WAIT && mul_done) begin
                ch_res         <= mul_res;
                ch_done[owner] <= 1'b1;
                pend[owner]    <= 1'b0;
            end
        end
    end

endmodule
